// File: rtl/mopshub_arb_pkg.sv
// Shared state type and bus sizing for the CAN receive arbiter.
package mopshub_arb_pkg;

    localparam int unsigned BUS_MAX = 32;
    localparam int unsigned BUS_W   = 5;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        WAIT,
        CLEAR
    } arb_state_t;

endpackage

// File: rtl/rr_priority_finder.sv
// Round-robin winner search: rotate requests so the bus after last_grant sits at bit 0,
// pick the lowest set bit, then rotate the index back.
module rr_priority_finder
    import mopshub_arb_pkg::*;
(
    input  logic [BUS_MAX-1:0] req,
    input  logic [BUS_W-1:0]   last_grant,
    input  logic [BUS_W-1:0]   n_buses,
    output logic [BUS_W-1:0]   winner,
    output logic               valid
);

    logic [BUS_W-1:0]   start;
    logic [BUS_W-1:0]   src_idx;
    logic [BUS_MAX-1:0] rotated;
    logic [BUS_W-1:0]   offset;

    // Requests above n_buses are already masked, so wrapping at BUS_MAX visits the
    // same buses in the same order as wrapping at n_buses+1.
    always_comb begin
        start = (last_grant >= n_buses) ? '0 : last_grant + BUS_W'(1);
    end

    always_comb begin
        rotated = '0;
        src_idx = '0;
        for (int i = 0; i < int'(BUS_MAX); i++) begin
            src_idx    = BUS_W'(i) + start;
            rotated[i] = req[src_idx];
        end
    end

    always_comb begin
        offset = '0;
        for (int i = int'(BUS_MAX) - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = BUS_W'(i);
            end
        end
    end

    always_comb begin
        valid  = |rotated;
        winner = start + offset;
    end

endmodule

// File: rtl/can_rec_arbiter.sv
// Round-robin scheduler sharing the CAN receive-to-uplink path among up to 32 controllers.
// Optional statistics counters are enabled by defining CAN_REC_ARB_STATS_EN.
module can_rec_arbiter
    import mopshub_arb_pkg::*;
#(
    parameter int unsigned N_BUSES     = 32,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BUS_W-1:0]   n_buses,
    input  logic               endwait_all,
    input  logic [N_BUSES-1:0] irq_can_rec,
    input  logic               rec_done,
    output logic [BUS_W-1:0]   can_rec_select,
    output logic               rec_start,
    output logic               rec_busy,
    output logic [N_BUSES-1:0] irq_clr,
    output logic               rec_timeout
`ifdef CAN_REC_ARB_STATS_EN
    ,
    output logic [15:0]        grant_cnt,
    output logic [7:0]         timeout_cnt
`endif
);

    localparam int unsigned      CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [BUS_W-1:0] LAST_RST = BUS_W'(N_BUSES - 1);

    arb_state_t         state;
    logic [BUS_W-1:0]   last_grant;
    logic [CNT_W-1:0]   tmo_cnt;
    logic [BUS_MAX-1:0] req;
    logic [N_BUSES-1:0] clr_onehot;
    logic [BUS_W-1:0]   winner;
    logic               win_valid;

    always_comb begin
        req = '0;
        for (int i = 0; i < int'(N_BUSES); i++) begin
            req[i] = irq_can_rec[i] && (i <= int'(n_buses));
        end
    end

    always_comb begin
        clr_onehot = '0;
        for (int i = 0; i < int'(N_BUSES); i++) begin
            clr_onehot[i] = (can_rec_select == BUS_W'(i));
        end
    end

    rr_priority_finder u_finder (
        .req        (req),
        .last_grant (last_grant),
        .n_buses    (n_buses),
        .winner     (winner),
        .valid      (win_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            can_rec_select <= '0;
            rec_start      <= 1'b0;
            rec_busy       <= 1'b0;
            irq_clr        <= '0;
            rec_timeout    <= 1'b0;
            last_grant     <= LAST_RST;
            tmo_cnt        <= '0;
        end else begin
            rec_start   <= 1'b0;
            irq_clr     <= '0;
            rec_timeout <= 1'b0;
            if (endwait_all) begin
                // Abort leaves last_grant alone so fairness resumes where it was.
                state    <= IDLE;
                rec_busy <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (win_valid) begin
                            can_rec_select <= winner;
                            rec_start      <= 1'b1;
                            rec_busy       <= 1'b1;
                            state          <= GRANT;
                        end
                    end
                    GRANT: begin
                        tmo_cnt <= '0;
                        state   <= WAIT;
                    end
                    WAIT: begin
                        if (rec_done) begin
                            irq_clr <= clr_onehot;
                            state   <= CLEAR;
                        end else if (tmo_cnt == TMO_LAST) begin
                            // Clear the request anyway so a dead bus cannot starve others.
                            rec_timeout <= 1'b1;
                            irq_clr     <= clr_onehot;
                            state       <= CLEAR;
                        end else begin
                            tmo_cnt <= tmo_cnt + CNT_W'(1);
                        end
                    end
                    CLEAR: begin
                        last_grant <= can_rec_select;
                        rec_busy   <= 1'b0;
                        state      <= IDLE;
                    end
                    default: begin
                        rec_busy <= 1'b0;
                        state    <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef CAN_REC_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_cnt   <= '0;
            timeout_cnt <= '0;
        end else begin
            if (rec_start && (grant_cnt != '1)) begin
                grant_cnt <= grant_cnt + 16'd1;
            end
            if (rec_timeout && (timeout_cnt != '1)) begin
                timeout_cnt <= timeout_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_can_rec_arbiter.sv
// Self-checking bench for can_rec_arbiter against a round-robin reference model.
`timescale 1ns/1ps
module tb_can_rec_arbiter;

    localparam int TIMEOUT_CYC = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  n_buses = 5'd31;
    logic        endwait_all = 1'b0;
    logic [31:0] irq_can_rec = '0;
    logic        rec_done = 1'b0;
    logic [4:0]  can_rec_select;
    logic        rec_start;
    logic        rec_busy;
    logic [31:0] irq_clr;
    logic        rec_timeout;
`ifdef CAN_REC_ARB_STATS_EN
    logic [15:0] grant_cnt;
    logic [7:0]  timeout_cnt;
`endif

    int errors = 0;
    int checks = 0;
    int model_last = 31;

    can_rec_arbiter #(
        .N_BUSES     (32),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .n_buses        (n_buses),
        .endwait_all    (endwait_all),
        .irq_can_rec    (irq_can_rec),
        .rec_done       (rec_done),
        .can_rec_select (can_rec_select),
        .rec_start      (rec_start),
        .rec_busy       (rec_busy),
        .irq_clr        (irq_clr),
        .rec_timeout    (rec_timeout)
`ifdef CAN_REC_ARB_STATS_EN
        ,
        .grant_cnt      (grant_cnt),
        .timeout_cnt    (timeout_cnt)
`endif
    );

    always #12.5 clk = ~clk;

    // Reference: scan buses base, base+1, ... modulo n+1; base restarts at 0 when last >= n.
    function automatic int ref_pick(input logic [31:0] r, input int last, input int n);
        int base;
        base = (last >= n) ? 0 : last + 1;
        for (int k = 0; k <= n; k++) begin
            int b;
            b = (base + k) % (n + 1);
            if (r[b]) return b;
        end
        return -1;
    endfunction

    function automatic logic [31:0] mask_of(input int n);
        return (n >= 31) ? 32'hFFFF_FFFF : ((32'd1 << (n + 1)) - 32'd1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        irq_can_rec = '0;
        rec_done = 1'b0;
        endwait_all = 1'b0;
        n_buses = 5'd31;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        model_last = 31;
    endtask

    task automatic wait_start(input int bound, output int sel, output bit got);
        got = 1'b0;
        sel = -1;
        for (int i = 0; i < bound && !got; i++) begin
            tick();
            if (rec_start === 1'b1) begin
                got = 1'b1;
                sel = int'(can_rec_select);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({can_rec_select, rec_start, rec_busy, rec_timeout} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl: got sel=%0d start=%b busy=%b tmo=%b required all 0",
                     can_rec_select, rec_start, rec_busy, rec_timeout);
        end
        checks++;
        if (irq_clr !== 32'h0) begin
            errors++;
            $display("FAIL reset_irq_clr: got %h required 0", irq_clr);
        end
`ifdef CAN_REC_ARB_STATS_EN
        checks++;
        if (grant_cnt !== 16'd0 || timeout_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_stats: got %0d/%0d required 0/0", grant_cnt, timeout_cnt);
        end
`endif
    endtask

    task automatic test_single();
        do_reset();
        rec_done = 1'b1;
        tick();
        rec_done = 1'b0;
        checks++;
        if (rec_busy !== 1'b0 || irq_clr !== 32'h0) begin
            errors++;
            $display("FAIL done_in_idle: got busy=%b clr=%h required 0/0", rec_busy, irq_clr);
        end
        irq_can_rec = 32'h0000_0010;
        tick();
        checks++;
        if (rec_start !== 1'b1 || can_rec_select !== 5'd4 || rec_busy !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: got start=%b sel=%0d busy=%b required 1/4/1",
                     rec_start, can_rec_select, rec_busy);
        end
        rec_done = 1'b1;  // during GRANT: must be ignored
        tick();
        rec_done = 1'b0;
        checks++;
        if (rec_start !== 1'b0 || irq_clr !== 32'h0 || rec_busy !== 1'b1) begin
            errors++;
            $display("FAIL single_pulse: got start=%b clr=%h busy=%b required 0/0/1",
                     rec_start, irq_clr, rec_busy);
        end
        repeat (4) tick();
        rec_done = 1'b1;
        tick();
        rec_done = 1'b0;
        checks++;
        if (irq_clr !== 32'h0000_0010 || rec_timeout !== 1'b0) begin
            errors++;
            $display("FAIL single_clr: got clr=%h tmo=%b required 00000010/0", irq_clr, rec_timeout);
        end
        irq_can_rec = '0;
        tick();
        checks++;
        if (irq_clr !== 32'h0 || rec_busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: got clr=%h busy=%b required 0/0", irq_clr, rec_busy);
        end
    endtask

    task automatic test_fairness();
        bit seen [32];
        int sel, exp;
        bit got;
        do_reset();
        foreach (seen[i]) seen[i] = 1'b0;
        irq_can_rec = 32'hFFFF_FFFF;
        for (int g = 0; g < 33; g++) begin
            exp = ref_pick(irq_can_rec, model_last, 31);
            wait_start(8, sel, got);
            checks++;
            if (!got || sel != exp) begin
                errors++;
                $display("FAIL rr_order[%0d]: got %0d required %0d", g, sel, exp);
            end
            if (!got) return;
            if (g < 32) begin
                checks++;
                if (seen[sel]) begin
                    errors++;
                    $display("FAIL rr_dup[%0d]: got bus %0d twice required once", g, sel);
                end
                seen[sel] = 1'b1;
            end
            repeat (3) tick();
            rec_done = 1'b1;
            tick();
            rec_done = 1'b0;
            checks++;
            if (irq_clr !== (32'd1 << exp)) begin
                errors++;
                $display("FAIL rr_clr[%0d]: got %h required %h", g, irq_clr, 32'd1 << exp);
            end
            model_last = exp;
        end
    endtask

    task automatic test_masking();
        int sel, exp;
        bit got;
        do_reset();
        n_buses = 5'd7;
        irq_can_rec = 32'hFFFF_FF00 | 32'h0000_0004;
        exp = ref_pick(irq_can_rec, model_last, 7);
        wait_start(8, sel, got);
        checks++;
        if (!got || sel != exp) begin
            errors++;
            $display("FAIL mask_grant: got %0d required %0d", sel, exp);
        end
        repeat (2) tick();
        rec_done = 1'b1;
        tick();
        rec_done = 1'b0;
        irq_can_rec[2] = 1'b0;
        wait_start(20, sel, got);
        checks++;
        if (got) begin
            errors++;
            $display("FAIL mask_block: got grant of bus %0d required none", sel);
        end
    endtask

    task automatic test_timeout();
        int sel, cyc;
        bit got, tmo;
        do_reset();
        irq_can_rec = 32'h0000_0200;
        wait_start(8, sel, got);
        checks++;
        if (!got || sel != 9) begin
            errors++;
            $display("FAIL tmo_grant: got %0d required 9", sel);
        end
        cyc = 0;
        tmo = 1'b0;
        while (cyc < TIMEOUT_CYC + 50 && !tmo) begin
            tick();
            cyc++;
            if (rec_timeout === 1'b1) tmo = 1'b1;
        end
        checks++;
        if (!tmo || cyc != TIMEOUT_CYC + 1) begin
            errors++;
            $display("FAIL tmo_latency: got pulse=%b after %0d cycles required 1 after %0d",
                     tmo, cyc, TIMEOUT_CYC + 1);
        end
        checks++;
        if (irq_clr !== 32'h0000_0200) begin
            errors++;
            $display("FAIL tmo_clr: got %h required 00000200", irq_clr);
        end
        irq_can_rec = '0;
        tick();
        checks++;
        if (rec_timeout !== 1'b0 || rec_busy !== 1'b0) begin
            errors++;
            $display("FAIL tmo_after: got tmo=%b busy=%b required 0/0", rec_timeout, rec_busy);
        end
`ifdef CAN_REC_ARB_STATS_EN
        checks++;
        if (timeout_cnt !== 8'd1 || grant_cnt !== 16'd1) begin
            errors++;
            $display("FAIL tmo_stats: got tmo_cnt=%0d grant_cnt=%0d required 1/1",
                     timeout_cnt, grant_cnt);
        end
`endif
    endtask

    task automatic test_simultaneous();
        int sel;
        bit got;
        do_reset();
        irq_can_rec = 32'h0000_1000;
        wait_start(8, sel, got);
        checks++;
        if (!got || sel != 12) begin
            errors++;
            $display("FAIL sim_grant: got %0d required 12", sel);
        end
        repeat (TIMEOUT_CYC) tick();
        rec_done = 1'b1;
        tick();
        rec_done = 1'b0;
        checks++;
        if (rec_timeout !== 1'b0 || irq_clr !== 32'h0000_1000) begin
            errors++;
            $display("FAIL sim_done_wins: got tmo=%b clr=%h required 0/00001000",
                     rec_timeout, irq_clr);
        end
        irq_can_rec = '0;
        tick();
        checks++;
        if (rec_timeout !== 1'b0 || rec_busy !== 1'b0) begin
            errors++;
            $display("FAIL sim_after: got tmo=%b busy=%b required 0/0", rec_timeout, rec_busy);
        end
`ifdef CAN_REC_ARB_STATS_EN
        checks++;
        if (timeout_cnt !== 8'd0) begin
            errors++;
            $display("FAIL sim_stats: got tmo_cnt=%0d required 0", timeout_cnt);
        end
`endif
    endtask

    task automatic test_abort();
        int sel, exp;
        bit got;
        do_reset();
        irq_can_rec = 32'h0000_000A;
        exp = ref_pick(irq_can_rec, model_last, 31);
        wait_start(8, sel, got);
        checks++;
        if (!got || sel != exp) begin
            errors++;
            $display("FAIL abort_first: got %0d required %0d", sel, exp);
        end
        repeat (2) tick();
        rec_done = 1'b1;
        tick();
        rec_done = 1'b0;
        model_last = exp;
        irq_can_rec[exp] = 1'b0;
        exp = ref_pick(irq_can_rec, model_last, 31);
        wait_start(8, sel, got);
        checks++;
        if (!got || sel != exp) begin
            errors++;
            $display("FAIL abort_second: got %0d required %0d", sel, exp);
        end
        repeat (2) tick();
        endwait_all = 1'b1;
        rec_done = 1'b1;  // abort must outrank completion
        tick();
        endwait_all = 1'b0;
        rec_done = 1'b0;
        checks++;
        if (rec_busy !== 1'b0 || irq_clr !== 32'h0 || rec_start !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: got busy=%b clr=%h start=%b required 0/0/0",
                     rec_busy, irq_clr, rec_start);
        end
        irq_can_rec = 32'h0000_0009;
        exp = ref_pick(irq_can_rec, model_last, 31);
        wait_start(8, sel, got);
        checks++;
        if (!got || sel != exp) begin
            errors++;
            $display("FAIL abort_resume: got %0d required %0d", sel, exp);
        end
    endtask

    task automatic test_reset_mid();
        int sel, exp;
        bit got;
        do_reset();
        irq_can_rec = 32'h0000_0040;
        wait_start(8, sel, got);
        repeat (2) tick();
        rec_done = 1'b1;
        tick();
        rec_done = 1'b0;
        model_last = 6;
        irq_can_rec = 32'h0000_0104;
        exp = ref_pick(irq_can_rec, model_last, 31);
        wait_start(8, sel, got);
        checks++;
        if (!got || sel != exp) begin
            errors++;
            $display("FAIL rstmid_grant: got %0d required %0d", sel, exp);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({can_rec_select, rec_start, rec_busy, rec_timeout} !== 8'h00 || irq_clr !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_async: got sel=%0d start=%b busy=%b clr=%h required all 0",
                     can_rec_select, rec_start, rec_busy, irq_clr);
        end
        repeat (2) tick();
        rst = 1'b1;
        model_last = 31;
        exp = ref_pick(irq_can_rec, model_last, 31);
        wait_start(8, sel, got);
        checks++;
        if (!got || sel != exp) begin
            errors++;
            $display("FAIL rstmid_prio: got %0d required %0d", sel, exp);
        end
    endtask

    task automatic test_random();
        logic [31:0] pend;
        int n, exp, sel, d;
        bit got;
        do_reset();
        n = 31;
        pend = $urandom;
        for (int it = 0; it < 40; it++) begin
            if ((pend & mask_of(n)) == 32'h0) pend[$urandom_range(n, 0)] = 1'b1;
            irq_can_rec = pend;
            n_buses = 5'(n);
            exp = ref_pick(pend, model_last, n);
            wait_start(8, sel, got);
            checks++;
            if (!got || sel != exp) begin
                errors++;
                $display("FAIL rand_grant[%0d]: got %0d required %0d (n=%0d last=%0d req=%h)",
                         it, sel, exp, n, model_last, pend);
            end
            if (!got) return;
            // Changes during the grant must only matter at the next arbitration.
            n = $urandom_range(31, 0);
            n_buses = 5'(n);
            pend = pend | ($urandom & $urandom);
            irq_can_rec = pend;
            d = $urandom_range(6, 1);
            repeat (d) tick();
            checks++;
            if (rec_busy !== 1'b1) begin
                errors++;
                $display("FAIL rand_busy[%0d]: got %b required 1", it, rec_busy);
            end
            rec_done = 1'b1;
            tick();
            rec_done = 1'b0;
            checks++;
            if (irq_clr !== (32'd1 << exp)) begin
                errors++;
                $display("FAIL rand_clr[%0d]: got %h required %h", it, irq_clr, 32'd1 << exp);
            end
            model_last = exp;
            pend[exp] = 1'b0;
            irq_can_rec = pend;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_masking();
        test_timeout();
        test_simultaneous();
        test_abort();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/can_rec_arbiter.md
Name: can_rec_arbiter

Overview:
- Round-robin scheduler that shares the single CAN-receive-to-uplink datapath among up to 32 CAN bus controllers.
- Watches per-bus message-pending requests and drives `can_rec_select` to one granted bus.
- Launches one uplink read per grant and waits for completion or timeout.
- Clears the served request, then moves on. Sits in mopshub_top between the CAN controller array and the elink transmit path.

Parameters:
- N_BUSES, 32, number of physical request lines (max 32).
- TIMEOUT_CYC, 1024, clk cycles to wait for rec_done before abandoning a grant.

Ports:
- clk  in  1  system clock (40 MHz).
- rst  in  1  asynchronous active-low reset.
- n_buses  in  5  index of highest enabled bus; request bits above it are masked.
- endwait_all  in  1  abort: drop current grant, return to IDLE.
- irq_can_rec  in  N_BUSES  level request per bus: message pending in controller.
- rec_done  in  1  pulse from uplink path: message from the selected bus fully latched.
- can_rec_select  out  5  index of granted bus; stable from GRANT through CLEAR.
- rec_start  out  1  one-cycle pulse: read the selected bus.
- rec_busy  out  1  high in GRANT, WAIT and CLEAR.
- irq_clr  out  N_BUSES  one-hot one-cycle pulse clearing the served bus request.
- rec_timeout  out  1  one-cycle pulse when a grant is abandoned.

Behaviour:
- Reset (rst=0, async): state=IDLE; can_rec_select=0; rec_start=0; rec_busy=0; irq_clr=0; rec_timeout=0; last_grant=N_BUSES-1, so bus 0 has first priority; timeout counter=0.
- Masked request vector: req = irq_can_rec & (bits 0..n_buses set).
- IDLE:
  - If req≠0, register the winner into can_rec_select and go to GRANT.
  - Winner = first set bit scanning last_grant+1, last_grant+2, … wrapping modulo n_buses+1.
  - Latency: request visible at edge t gives a valid can_rec_select and rec_start=1 during cycle t+1.
- GRANT:
  - rec_start=1 for exactly one cycle.
  - Clear the timeout counter.
  - Go to WAIT.
- WAIT:
  - Increment the timeout counter.
  - rec_done=1: go to CLEAR.
  - Counter reaches TIMEOUT_CYC-1 without rec_done: pulse rec_timeout, go to CLEAR.
  - rec_done and timeout in the same cycle: rec_done wins, no rec_timeout.
- CLEAR:
  - irq_clr[can_rec_select]=1 for one cycle (also after a timeout, so a dead bus cannot starve others).
  - last_grant <= can_rec_select.
  - Go to IDLE. The next arbitration starts the following cycle, so there is at least one idle cycle between grants.
- endwait_all:
  - In any state, go to IDLE next cycle and cancel any pending pulse.
  - irq_clr is not issued; last_grant is unchanged.
  - Has priority over rec_done and timeout.
- Request deasserting during WAIT: no effect; the grant is held until done, timeout or abort.
- n_buses change:
  - Sampled only in IDLE.
  - If last_grant > n_buses, the scan restarts at bus 0.
- rec_done outside WAIT: ignored.
- Timeout counter width: $clog2(TIMEOUT_CYC); no wrap, because the terminal count exits WAIT.

Optional Feature:
- Macro: CAN_REC_ARB_STATS_EN.
- When defined:
  - Adds outputs grant_cnt[15:0] and timeout_cnt[7:0], both reset to 0.
  - grant_cnt increments on every GRANT entry.
  - timeout_cnt increments on every rec_timeout pulse.
  - Both saturate at all-ones.
- When undefined: ports and logic are absent; core behaviour is identical.

Decomposition:
- Package mopshub_arb_pkg holds:
  - the state enum arb_state_t {IDLE, GRANT, WAIT, CLEAR};
  - localparams BUS_MAX=32 and BUS_W=5.
- One sub-module, rr_priority_finder: combinational.
  - Inputs: req, last_grant, n_buses.
  - Outputs: winner index and a valid flag.
  - Implementation: rotate, priority-encode, un-rotate.

Test Plan:
- Single request: irq_can_rec=32'h0000_0010 after reset.
  - can_rec_select=4 and rec_start pulse 1 cycle later.
  - rec_done 5 cycles later, then irq_clr=32'h10 next cycle.
- Round-robin fairness: all 32 requests held high, rec_done returned 3 cycles after each rec_start.
  - Grant order 0,1,…,31,0; no bus granted twice in 32 grants.
- Masking: n_buses=7, requests 32'hFFFF_FF00 | 32'h0000_0004.
  - Only bus 2 is granted; buses 8–31 are never selected.
- Timeout: request bus 9, never assert rec_done.
  - rec_timeout pulses after TIMEOUT_CYC cycles in WAIT.
  - irq_clr[9] pulses; with CAN_REC_ARB_STATS_EN, timeout_cnt=1.
- Abort and reset mid-operation:
  - endwait_all during WAIT on bus 3: IDLE next cycle, no irq_clr, next grant still starts search at last_grant+1.
  - rst low during GRANT: all outputs 0 immediately, bus 0 has first priority after release.
- Simultaneous events: rec_done and terminal timeout in the same cycle.
  - No rec_timeout pulse; normal CLEAR.
